rgb_pixel_proc: RTL and testbench
=================================

// Module: rgb_pixel_proc
// PURPOSE
//  Pixel-stream processing stage between the Bayer-to-RGB demosaic and the SDRAM write FIFOs,
//  clocked on the camera pixel clock. Applies a per-frame selectable transform to the RGB
//  stream: passthrough, grayscale, binary threshold or invert.
//  Also measures the mean frame luminance for exposure/debug display.
// PARAMETERS
//  DATA_W  12  bits per colour channel in/out
//  ACC_W   32  luminance accumulator width (640x480x4095 < 2^31)
//  CNT_W   20  valid-pixel counter width
// PORTS
//  iCLK        in   1       pixel clock (CCD_PIXCLK)
//  iRST_N      in   1       asynchronous active-low reset
//  iRed        in   DATA_W  demosaiced red
//  iGreen      in   DATA_W  demosaiced green
//  iBlue       in   DATA_W  demosaiced blue
//  iDVAL       in   1       input pixel valid
//  iFVAL       in   1       frame valid (high for the whole active frame)
//  iMODE       in   2       0 pass, 1 gray, 2 threshold, 3 invert
//  iTHRESH     in   DATA_W  threshold for mode 2
//  oRed        out  DATA_W  processed red
//  oGreen      out  DATA_W  processed green
//  oBlue       out  DATA_W  processed blue
//  oDVAL       out  1       output pixel valid
//  oLUMA_AVG   out  DATA_W  mean luminance of the last completed frame
//  oAVG_VALID  out  1       one-cycle pulse when oLUMA_AVG updates
//  oOVERRUN    out  1       sticky: a frame ended while the divider was busy
// BEHAVIOUR
//  - Reset: all outputs 0; mode/threshold registers 0; accumulator and counter cleared; divider idle.
//  - Luma: Y = (77*R + 150*G + 29*B) >> 8, 20-bit intermediate, unsigned.
//    Coefficients sum to 256, so Y <= 4095 and R=G=B=v gives Y=v exactly.
//  - Pipeline: fixed latency 3. S1 registers products + RGB.
//    S2 registers Y + RGB. S3 applies the mode mux.
//    oDVAL = iDVAL delayed 3 cycles. No stalls, no backpressure.
//    Data on invalid cycles propagates but is don't-care.
//  - Mode outputs:
//      pass:   RGB unchanged.
//      gray:   R=G=B=Y.
//      thresh: R=G=B = (Y >= THRESH) ? 4095 : 0.
//      invert: each channel = 4095 - ch.
//  - iMODE and iTHRESH are sampled only on the rising edge of iFVAL (registered-iFVAL edge detect).
//    Changes mid-frame take effect at the next frame start.
//    Before the first frame, mode = pass.
//  - Stats:
//    - Frame start/end events are delayed 2 cycles to align with S2.
//    - Aligned start clears the accumulator and counter.
//    - Each S2-valid cycle adds Y and increments the count. Count saturates at 2^CNT_W-1.
//    - On aligned end, sum/count are latched and the divider starts.
//  - Divider: restoring, unsigned, ACC_W/CNT_W, 1 quotient bit per cycle.
//    States IDLE -> RUN (ACC_W cycles) -> DONE (1 cycle) -> IDLE.
//    In DONE: oLUMA_AVG <= quotient[DATA_W-1:0] and oAVG_VALID pulses.
//    Count of 0 yields average 0 with no divide, and DONE follows on the next cycle.
//  - Frame end while the divider is not IDLE: new totals are discarded, the current division completes, and oOVERRUN sets.
//    oOVERRUN clears only on reset.
//  - Simultaneous aligned end and start (FVAL low for 1 cycle): end latches first, then the clear applies the same cycle.
//    The latched totals are unaffected.
//  - Reset mid-frame: everything is cleared. The first post-reset frame end is ignored unless its start was seen.
// STRUCTURE
//  - Shared package pix_proc_pkg:
//    - mode encodings MODE_PASS/GRAY/THRESH/INV
//    - luma coefficients KR=77, KG=150, KB=29 and shift 8
//    - PIX_MAX = 4095
//  - One sub-module: luma_avg_div, the sequential restoring divider with start/busy/done handshake.
//  - Top holds the pipeline, edge detect and accumulators.
// TESTING
//  1. Reset held low, iDVAL=1 with pixels -> oDVAL=0, all data 0, oLUMA_AVG=0, oAVG_VALID=0.
//  2. Mode 0, pixel (100,200,300) valid at cycle t -> oDVAL=1 and (100,200,300) at t+3.
//  3. Mode 1: (1000,0,0) -> (300,300,300); (4095,4095,4095) -> (4095,4095,4095).
//  4. Mode 2, THRESH=2048: gray 2047 -> (0,0,0); gray 2048 -> (4095,4095,4095).
//     Mode 3: (0,100,4095) -> (4095,3995,0).
//  5. Mode 0 latched; iMODE set to 3 with iFVAL high -> output stays passthrough.
//     After the next iFVAL rise -> output is inverted.
//  6. Frame of 4 gray pixels 100,200,300,400 -> oLUMA_AVG=250 with a single oAVG_VALID pulse
//     within 40 cycles of iFVAL falling.
//     Empty frame -> oLUMA_AVG=0.
//     Second frame ending 5 cycles after the first -> oOVERRUN=1 and the first result is still reported.

Source files
------------

// File: rtl/pix_proc_pkg.sv
// -----------------------------------------------------------------------------
// pix_proc_pkg
//   Shared definitions for the RGB pixel-processing stage: transform mode
//   encodings, BT.601-style integer luma coefficients, the full-scale pixel
//   value and the luma-average divider state encoding.
//   No ports (package).
// -----------------------------------------------------------------------------
package pix_proc_pkg;

   typedef enum logic [1:0] {
      MODE_PASS   = 2'd0,
      MODE_GRAY   = 2'd1,
      MODE_THRESH = 2'd2,
      MODE_INV    = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // Coefficients sum to 2^LUMA_SHIFT, so a gray pixel maps to itself exactly.
   localparam int KR         = 77;
   localparam int KG         = 150;
   localparam int KB         = 29;
   localparam int LUMA_SHIFT = 8;

   localparam int PIX_MAX    = 4095;

endpackage

// File: rtl/luma_avg_div.sv
// -----------------------------------------------------------------------------
// luma_avg_div
//   Sequential restoring unsigned divider producing the mean frame luminance
//   (sum / count), one quotient bit per clock, MSB first.
//   IDLE -> RUN (ACC_W cycles) -> DONE (1 cycle) -> IDLE.
//   A zero divisor skips RUN and reports 0.
// Ports
//   clk       in   1       clock
//   rst_n     in   1       asynchronous active-low reset
//   start     in   1       capture operands and begin (honoured only in IDLE)
//   dividend  in   ACC_W   luminance sum
//   divisor   in   CNT_W   pixel count
//   busy      out  1       divider not IDLE
//   done      out  1       one-cycle pulse, quotient valid from this cycle on
//   quotient  out  DATA_W  low DATA_W bits of the quotient (held until next done)
// -----------------------------------------------------------------------------
module luma_avg_div
   import pix_proc_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int ACC_W  = 32,
   parameter int CNT_W  = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ACC_W-1:0]  dividend,
   input  logic [CNT_W-1:0]  divisor,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] quotient
);

   localparam int BIT_CNT_W = $clog2(ACC_W) + 1;

   div_state_e           state;
   logic [ACC_W-1:0]     dvd;      // dividend bits shift out the top, quotient bits shift in below
   logic [CNT_W-1:0]     dsr;
   logic [CNT_W-1:0]     rem;
   logic [BIT_CNT_W-1:0] bit_cnt;

   logic [CNT_W:0]       trial;
   logic                 trial_ge;

   // rem < dsr always holds, so one extra bit is enough for the trial value.
   assign trial    = {rem, dvd[ACC_W-1]};
   assign trial_ge = (trial >= {1'b0, dsr});
   assign busy     = (state != DIV_IDLE);

   // NOTE: sequential state is assigned with <= so every register samples the
   // pre-edge values; blocking assignments here would chain updates within one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= DIV_IDLE;
         // NOTE: datapath registers are reset too; the quotient drives a
         // visible output that must read 0 out of reset.
         dvd      <= '0;
         dsr      <= '0;
         rem      <= '0;
         bit_cnt  <= '0;
         done     <= 1'b0;
         quotient <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  dsr     <= divisor;
                  rem     <= '0;
                  bit_cnt <= '0;
                  if (divisor == '0) begin
                     dvd   <= '0;
                     state <= DIV_DONE;
                  end else begin
                     dvd   <= dividend;
                     state <= DIV_RUN;
                  end
               end
            end
            DIV_RUN: begin
               rem     <= trial_ge ? CNT_W'(trial - {1'b0, dsr}) : trial[CNT_W-1:0];
               dvd     <= {dvd[ACC_W-2:0], trial_ge};
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == BIT_CNT_W'(ACC_W - 1)) begin
                  state <= DIV_DONE;
               end
            end
            DIV_DONE: begin
               quotient <= dvd[DATA_W-1:0];
               done     <= 1'b1;
               state    <= DIV_IDLE;
            end
            default: state <= DIV_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/rgb_pixel_proc.sv
// -----------------------------------------------------------------------------
// rgb_pixel_proc
//   Pixel-stream stage between the demosaic and the SDRAM write FIFOs.
//   3-cycle pipeline applying a per-frame transform (pass / gray / threshold /
//   invert) plus a mean-frame-luminance measurement.
// Ports
//   iCLK        in   1       pixel clock
//   iRST_N      in   1       asynchronous active-low reset
//   iRed/iGreen/iBlue in DATA_W  demosaiced pixel
//   iDVAL       in   1       input pixel valid
//   iFVAL       in   1       frame valid
//   iMODE       in   2       0 pass, 1 gray, 2 threshold, 3 invert (latched at frame start)
//   iTHRESH     in   DATA_W  threshold for mode 2 (latched at frame start)
//   oRed/oGreen/oBlue out DATA_W processed pixel
//   oDVAL       out  1       iDVAL delayed 3 cycles
//   oLUMA_AVG   out  DATA_W  mean luminance of the last completed frame
//   oAVG_VALID  out  1       one-cycle pulse when oLUMA_AVG updates
//   oOVERRUN    out  1       sticky: a frame ended while the divider was busy
// -----------------------------------------------------------------------------
module rgb_pixel_proc
   import pix_proc_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int ACC_W  = 32,
   parameter int CNT_W  = 20
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic [DATA_W-1:0] iRed,
   input  logic [DATA_W-1:0] iGreen,
   input  logic [DATA_W-1:0] iBlue,
   input  logic              iDVAL,
   input  logic              iFVAL,
   input  logic [1:0]        iMODE,
   input  logic [DATA_W-1:0] iTHRESH,
   output logic [DATA_W-1:0] oRed,
   output logic [DATA_W-1:0] oGreen,
   output logic [DATA_W-1:0] oBlue,
   output logic              oDVAL,
   output logic [DATA_W-1:0] oLUMA_AVG,
   output logic              oAVG_VALID,
   output logic              oOVERRUN
);

   // Largest coefficient is < 2^8 and the weighted sum is <= 256*max, so
   // DATA_W+8 bits hold every product and their sum.
   localparam int                PROD_W  = DATA_W + LUMA_SHIFT;
   localparam logic [DATA_W-1:0] PIX_TOP = DATA_W'(PIX_MAX);

   // ---------------- frame edge detect and per-frame configuration ----------
   logic              fval_q;
   logic              frame_start;
   logic              frame_end;
   mode_e             mode_r;
   logic [DATA_W-1:0] thresh_r;

   assign frame_start = iFVAL & ~fval_q;
   assign frame_end   = ~iFVAL & fval_q;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         // Treat "frame valid" as already high so a frame in progress at reset
         // release is not mistaken for a fresh start.
         fval_q   <= 1'b1;
         mode_r   <= MODE_PASS;
         thresh_r <= '0;
      end else begin
         fval_q <= iFVAL;
         if (frame_start) begin
            mode_r   <= mode_e'(iMODE);
            thresh_r <= iTHRESH;
         end
      end
   end

   // ---------------- pixel pipeline ----------------------------------------
   logic              s1_v, s2_v;
   logic [DATA_W-1:0] s1_r, s1_g, s1_b;
   logic [DATA_W-1:0] s2_r, s2_g, s2_b, s2_y;
   logic [PROD_W-1:0] s1_pr, s1_pg, s1_pb;
   logic [PROD_W-1:0] luma_sum;
   logic [DATA_W-1:0] mux_r, mux_g, mux_b;

   assign luma_sum = s1_pr + s1_pg + s1_pb;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      mux_r = s2_r;
      mux_g = s2_g;
      mux_b = s2_b;
      case (mode_r)
         MODE_PASS: ;
         MODE_GRAY: begin
            mux_r = s2_y;
            mux_g = s2_y;
            mux_b = s2_y;
         end
         MODE_THRESH: begin
            mux_r = (s2_y >= thresh_r) ? PIX_TOP : '0;
            mux_g = mux_r;
            mux_b = mux_r;
         end
         MODE_INV: begin
            mux_r = PIX_TOP - s2_r;
            mux_g = PIX_TOP - s2_g;
            mux_b = PIX_TOP - s2_b;
         end
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         s1_v  <= 1'b0;  s1_r  <= '0;  s1_g  <= '0;  s1_b <= '0;
         s1_pr <= '0;    s1_pg <= '0;  s1_pb <= '0;
         s2_v  <= 1'b0;  s2_r  <= '0;  s2_g  <= '0;  s2_b <= '0;  s2_y <= '0;
         oDVAL <= 1'b0;  oRed  <= '0;  oGreen <= '0; oBlue <= '0;
      end else begin
         // S1: weighted products
         s1_v  <= iDVAL;
         s1_r  <= iRed;
         s1_g  <= iGreen;
         s1_b  <= iBlue;
         s1_pr <= PROD_W'(KR) * PROD_W'(iRed);
         s1_pg <= PROD_W'(KG) * PROD_W'(iGreen);
         s1_pb <= PROD_W'(KB) * PROD_W'(iBlue);
         // S2: luma
         s2_v  <= s1_v;
         s2_r  <= s1_r;
         s2_g  <= s1_g;
         s2_b  <= s1_b;
         s2_y  <= DATA_W'(luma_sum >> LUMA_SHIFT);
         // S3: mode mux
         oDVAL  <= s2_v;
         oRed   <= mux_r;
         oGreen <= mux_g;
         oBlue  <= mux_b;
      end
   end

   // ---------------- frame luminance statistics ----------------------------
   // Frame events are delayed two cycles so they line up with pixels in S2.
   logic [1:0]       start_pipe, end_pipe;
   logic             start_al, end_al;
   logic             in_frame;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic             div_busy;
   logic             div_start;

   assign start_al  = start_pipe[1];
   assign end_al    = end_pipe[1];
   // The divider captures acc/cnt at this edge, before any same-cycle clear.
   assign div_start = end_al & in_frame & ~div_busy;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         start_pipe <= '0;
         end_pipe   <= '0;
         in_frame   <= 1'b0;
         acc        <= '0;
         cnt        <= '0;
         oOVERRUN   <= 1'b0;
      end else begin
         start_pipe <= {start_pipe[0], frame_start};
         end_pipe   <= {end_pipe[0], frame_end};

         if (end_al && in_frame && div_busy) begin
            oOVERRUN <= 1'b1;
         end

         if (start_al) begin
            in_frame <= 1'b1;
            acc      <= s2_v ? ACC_W'(s2_y) : '0;
            cnt      <= s2_v ? CNT_W'(1) : '0;
         end else begin
            if (end_al) begin
               in_frame <= 1'b0;
            end
            if (s2_v) begin
               acc <= acc + ACC_W'(s2_y);
               if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end
         end
      end
   end

   luma_avg_div #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .CNT_W  (CNT_W)
   ) u_div (
      .clk      (iCLK),
      .rst_n    (iRST_N),
      .start    (div_start),
      .dividend (acc),
      .divisor  (cnt),
      .busy     (div_busy),
      .done     (oAVG_VALID),
      .quotient (oLUMA_AVG)
   );

endmodule

// File: tb/tb_rgb_pixel_proc.sv
// -----------------------------------------------------------------------------
// tb_rgb_pixel_proc
//   Directed bench for rgb_pixel_proc. A behavioural model derives every
//   output pixel from the input pixel and the mode latched at its frame start,
//   delayed three cycles; frame averages come from plain sum/count of luma.
//   Hand-computed literal expectations ride along with selected pixels.
// -----------------------------------------------------------------------------
module tb_rgb_pixel_proc;

   localparam int DATA_W = 12;

   logic              iCLK = 1'b0;
   logic              iRST_N;
   logic [DATA_W-1:0] iRed, iGreen, iBlue, iTHRESH;
   logic              iDVAL, iFVAL;
   logic [1:0]        iMODE;
   logic [DATA_W-1:0] oRed, oGreen, oBlue, oLUMA_AVG;
   logic              oDVAL, oAVG_VALID, oOVERRUN;

   rgb_pixel_proc #(.DATA_W(DATA_W), .ACC_W(32), .CNT_W(20)) dut (
      .iCLK       (iCLK),
      .iRST_N     (iRST_N),
      .iRed       (iRed),
      .iGreen     (iGreen),
      .iBlue      (iBlue),
      .iDVAL      (iDVAL),
      .iFVAL      (iFVAL),
      .iMODE      (iMODE),
      .iTHRESH    (iTHRESH),
      .oRed       (oRed),
      .oGreen     (oGreen),
      .oBlue      (oBlue),
      .oDVAL      (oDVAL),
      .oLUMA_AVG  (oLUMA_AVG),
      .oAVG_VALID (oAVG_VALID),
      .oOVERRUN   (oOVERRUN)
   );

   always #5 iCLK = ~iCLK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model -------------------------------------
   typedef struct {
      logic     v;
      int       r, g, b;
      logic     lit;
      int       lr, lg, lb;
   } exp_t;

   exp_t pipe [3];
   int   m_mode, m_thr;
   logic m_prev_fval;
   logic lit_req;
   int   lit_r, lit_g, lit_b;
   logic cmp_en = 1'b0;

   function automatic int luma(input int r, input int g, input int b);
      return (77 * r + 150 * g + 29 * b) / 256;
   endfunction

   function automatic exp_t xform(input int r, input int g, input int b,
                                  input int mode, input int thr, input logic v);
      exp_t e;
      int   y;
      y    = luma(r, g, b);
      e.v  = v;
      e.lit = 1'b0;
      e.lr = 0; e.lg = 0; e.lb = 0;
      case (mode)
         1:       begin e.r = y; e.g = y; e.b = y; end
         2:       begin e.r = (y >= thr) ? 4095 : 0; e.g = e.r; e.b = e.r; end
         3:       begin e.r = 4095 - r; e.g = 4095 - g; e.b = 4095 - b; end
         default: begin e.r = r; e.g = g; e.b = b; end
      endcase
      return e;
   endfunction

   always @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         for (int i = 0; i < 3; i++) begin
            pipe[i] <= '{v: 1'b0, r: 0, g: 0, b: 0, lit: 1'b0, lr: 0, lg: 0, lb: 0};
         end
         m_mode      <= 0;
         m_thr       <= 0;
         m_prev_fval <= 1'b0;
      end else begin
         exp_t e;
         int   cur_mode, cur_thr;
         cur_mode = (iFVAL && !m_prev_fval) ? int'(iMODE)   : m_mode;
         cur_thr  = (iFVAL && !m_prev_fval) ? int'(iTHRESH) : m_thr;
         e     = xform(int'(iRed), int'(iGreen), int'(iBlue), cur_mode, cur_thr, iDVAL);
         e.lit = lit_req;
         e.lr  = lit_r; e.lg = lit_g; e.lb = lit_b;
         m_mode      <= cur_mode;
         m_thr       <= cur_thr;
         m_prev_fval <= iFVAL;
         pipe[0] <= e;
         pipe[1] <= pipe[0];
         pipe[2] <= pipe[1];
      end
   end

   // Single compare process: pixel outputs against the model every cycle.
   always @(negedge iCLK) begin
      if (iRST_N && cmp_en) begin
         check("dval", {31'd0, oDVAL}, {31'd0, pipe[2].v});
         if (pipe[2].v) begin
            check("red",   32'(oRed),   32'(pipe[2].r));
            check("green", 32'(oGreen), 32'(pipe[2].g));
            check("blue",  32'(oBlue),  32'(pipe[2].b));
         end
         if (pipe[2].lit) begin
            check("lit_red",   32'(oRed),   32'(pipe[2].lr));
            check("lit_green", 32'(oGreen), 32'(pipe[2].lg));
            check("lit_blue",  32'(oBlue),  32'(pipe[2].lb));
         end
      end
   end

   // Average-pulse monitor.
   int pulse_cnt = 0;
   int last_avg  = -1;
   always @(negedge iCLK) begin
      if (iRST_N && oAVG_VALID) begin
         pulse_cnt++;
         last_avg = int'(oLUMA_AVG);
      end
   end

   // ---------------- stimulus ----------------------------------------------
   int f_sum, f_cnt, f_exp;

   task automatic step(input int r, input int g, input int b, input logic dv,
                       input logic lit = 1'b0, input int lr = 0, input int lg = 0, input int lb = 0);
      @(negedge iCLK);
      iRed    = DATA_W'(r);
      iGreen  = DATA_W'(g);
      iBlue   = DATA_W'(b);
      iDVAL   = dv;
      lit_req = lit;
      lit_r   = lr; lit_g = lg; lit_b = lb;
      if (dv && iFVAL) begin
         f_sum += luma(r, g, b);
         f_cnt++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 1'b0);
   endtask

   task automatic set_fval(input logic v);
      @(negedge iCLK);
      iFVAL   = v;
      iDVAL   = 1'b0;
      lit_req = 1'b0;
      if (v) begin
         f_sum = 0;
         f_cnt = 0;
      end else begin
         f_exp = (f_cnt != 0) ? f_sum / f_cnt : 0;
      end
   endtask

   // Check exactly one average pulse carrying exp within the remaining window.
   task automatic wait_avg(input string name, input int exp, input int window);
      repeat (window) @(negedge iCLK);
      check({name, "_pulses"}, 32'(pulse_cnt), 32'd1);
      check({name, "_value"},  32'(last_avg),  32'(exp));
      check({name, "_out"},    32'(oLUMA_AVG), 32'(exp));
   endtask

   task automatic end_frame(input string name, input int lit_avg = -1);
      pulse_cnt = 0;
      last_avg  = -1;
      set_fval(1'b0);
      wait_avg(name, (lit_avg >= 0) ? lit_avg : f_exp, 40);
   endtask

   initial begin
      iRST_N  = 1'b0;
      iFVAL   = 1'b0;
      iDVAL   = 1'b1;
      iMODE   = 2'd0;
      iTHRESH = '0;
      iRed    = 12'd100; iGreen = 12'd200; iBlue = 12'd300;
      lit_req = 1'b0; lit_r = 0; lit_g = 0; lit_b = 0;

      // Reset held low with valid pixels streaming in.
      for (int i = 0; i < 4; i++) begin
         @(negedge iCLK);
         iRed = DATA_W'(100 * i + 7);
         check("rst_dval",  {31'd0, oDVAL}, 32'd0);
         check("rst_rgb",   {oRed, oGreen, oBlue} == '0 ? 32'd0 : 32'd1, 32'd0);
         check("rst_avg",   32'(oLUMA_AVG), 32'd0);
         check("rst_valid", {31'd0, oAVG_VALID}, 32'd0);
         check("rst_ovr",   {31'd0, oOVERRUN}, 32'd0);
      end
      @(negedge iCLK);
      iRST_N = 1'b1;
      iDVAL  = 1'b0;
      cmp_en = 1'b1;
      idle(4);

      // Frame A: passthrough; mode change mid-frame must not take effect.
      iMODE = 2'd0;
      set_fval(1'b1);
      step(100, 200, 300, 1'b1, 1'b1, 100, 200, 300);
      step(4000, 5, 77, 1'b1);
      idle(1);
      iMODE = 2'd3;
      step(10, 20, 30, 1'b1, 1'b1, 10, 20, 30);
      idle(4);
      end_frame("avg_a");

      // Frame B: invert now latched.
      set_fval(1'b1);
      step(0, 100, 4095, 1'b1, 1'b1, 4095, 3995, 0);
      step(10, 20, 30, 1'b1, 1'b1, 4085, 4075, 4065);
      idle(4);
      end_frame("avg_b");

      // Frame C: grayscale.
      iMODE = 2'd1;
      set_fval(1'b1);
      step(1000, 0, 0, 1'b1, 1'b1, 300, 300, 300);
      step(4095, 4095, 4095, 1'b1, 1'b1, 4095, 4095, 4095);
      step(0, 0, 0, 1'b1, 1'b1, 0, 0, 0);
      idle(4);
      end_frame("avg_c");

      // Frame D: threshold at 2048.
      iMODE   = 2'd2;
      iTHRESH = 12'd2048;
      set_fval(1'b1);
      step(2047, 2047, 2047, 1'b1, 1'b1, 0, 0, 0);
      step(2048, 2048, 2048, 1'b1, 1'b1, 4095, 4095, 4095);
      step(4095, 0, 0, 1'b1);
      idle(4);
      end_frame("avg_d");

      // Frame E: four gray pixels -> mean 250.
      iMODE = 2'd0;
      set_fval(1'b1);
      step(100, 100, 100, 1'b1, 1'b1, 100, 100, 100);
      step(200, 200, 200, 1'b1, 1'b1, 200, 200, 200);
      step(300, 300, 300, 1'b1, 1'b1, 300, 300, 300);
      step(400, 400, 400, 1'b1, 1'b1, 400, 400, 400);
      idle(4);
      end_frame("avg_e", 250);

      // Empty frame -> mean 0.
      set_fval(1'b1);
      idle(3);
      end_frame("avg_empty", 0);

      // Overrun: a second frame ends 5 cycles after the first.
      check("ovr_before", {31'd0, oOVERRUN}, 32'd0);
      set_fval(1'b1);
      step(100, 100, 100, 1'b1);
      step(200, 200, 200, 1'b1);
      idle(2);
      pulse_cnt = 0;
      last_avg  = -1;
      set_fval(1'b0);          // first frame ends
      set_fval(1'b1);          // second frame: FVAL low for one cycle only
      step(900, 900, 900, 1'b1);
      idle(2);
      set_fval(1'b0);          // second frame ends 5 cycles later
      wait_avg("avg_ovr", 150, 35);
      check("ovr_after", {31'd0, oOVERRUN}, 32'd1);
      idle(40);
      check("ovr_no_second", 32'(pulse_cnt), 32'd1);
      check("ovr_sticky", {31'd0, oOVERRUN}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
